mem_wb_lsu: RTL and testbench
=============================

// Module: mem_wb_lsu
// PURPOSE
//  MEM-stage load/store unit; consumes the EX/MEM pipeline register outputs (*M signals).
//  Drives a req/gnt/rvalid data-memory port and stalls the front of the pipe until each access completes.
//  Registers results into the MEM/WB boundary (*W signals) for the writeback mux.
// PARAMETERS
//  DATA_W   32  data/address width
//  REG_W    5   register-index width
//  TIMEOUT  16  max WAIT cycles for rvalid before a bus error; 0 = no timeout
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high reset
//  RegWriteM    in   1       register writeback enable from EX/MEM
//  MemtoRegM    in   1       load: writeback takes memory data
//  MemWriteM    in   1       store
//  ALUOutM      in   DATA_W  effective address / ALU result
//  WriteDataM   in   DATA_W  store data
//  WriteRegM    in   REG_W   destination register
//  StallM       out  1       hold EX/MEM and all earlier stages this cycle
//  dmem_req     out  1       memory request valid
//  dmem_we      out  1       1 = write, 0 = read
//  dmem_addr    out  DATA_W  = ALUOutM
//  dmem_wdata   out  DATA_W  = WriteDataM
//  dmem_gnt     in   1       request accepted this cycle
//  dmem_rvalid  in   1       read data valid
//  dmem_rdata   in   DATA_W  read data
//  RegWriteW    out  1       to WB
//  MemtoRegW    out  1       to WB
//  ReadDataW    out  DATA_W  load data to WB
//  ALUOutW      out  DATA_W  ALU result to WB
//  WriteRegW    out  REG_W   destination register to WB
//  bus_err      out  1       1-cycle pulse on timeout
// BEHAVIOUR
//  - Reset: state IDLE, timeout counter 0; all W outputs, bus_err and dmem_req are 0.
//  - memop = MemtoRegM | MemWriteM. Non-memop: no request, StallM=0; W registers latch M values next edge (1-cycle latency).
//  - FSM {IDLE, WAIT}:
//      IDLE + memop: dmem_req=1 combinationally.
//        Store + gnt: store done; go to IDLE.
//        Load + gnt + rvalid (same cycle): load done; go to IDLE.
//        Load + gnt without rvalid: go to WAIT.
//        No gnt: remain in IDLE and keep requesting; M inputs are held by StallM.
//      WAIT: dmem_req=0; counter increments each cycle.
//        rvalid: load done; go to IDLE.
//        counter==TIMEOUT-1 (TIMEOUT!=0): done with ReadDataW=0, bus_err pulse; go to IDLE.
//  - StallM = memop & ~done (combinational).
//  - Edge with done (or with a non-memop): W regs load RegWriteM, MemtoRegM, ALUOutM, WriteRegM;
//    ReadDataW = dmem_rdata for loads, 0 otherwise.
//  - Edge with stall: W regs load a bubble (RegWriteW=0, MemtoRegW=0); other W values hold.
//  - rvalid in IDLE with no load outstanding is ignored.
//  - gnt while dmem_req=0 is ignored.
//  - Reset mid-access: FSM returns to IDLE; late rvalid is dropped.
//  - Exactly one request per memop; the address/data never change while dmem_req=1 and gnt=0.
// CONFIGURATION
//  MEM_MISALIGN_CHECK_EN defined:
//    - memop with ALUOutM[1:0]!=0 issues no request.
//    - Completes in the same cycle (StallM=0); the W edge loads a bubble with RegWriteW=0.
//    - bus_err pulses 1 cycle.
//  MEM_MISALIGN_CHECK_EN undefined: address passed unchanged; no alignment check.
// STRUCTURE
//  - Shared package mips_pkg: lsu_state_e {IDLE, WAIT}, DATA_W/REG_W constants, BUS_ERR_RDATA = 0.
//  - Sub-module mem_wb_reg: MEM/WB register with load/bubble select.
//  - FSM and timeout counter stay in mem_wb_lsu.
// TESTING
//  1. ALU op: RegWriteM=1, ALUOutM=0x1234, WriteRegM=5
//     -> StallM=0, no dmem_req; next cycle RegWriteW=1, ALUOutW=0x1234, WriteRegW=5.
//  2. Store to 0x40, data 0xCAFE, gnt after 2 cycles
//     -> dmem_req/we=1 for 3 cycles with stable addr/wdata; StallM=1 for 2 cycles; then bubble to W.
//  3. Load from 0x80, gnt immediately, rvalid 3 cycles later with 0xBEEF
//     -> StallM=1 for 3 cycles; then RegWriteW=1, MemtoRegW=1, ReadDataW=0xBEEF.
//  4. Load, zero-wait memory (gnt+rvalid same cycle, 0x55)
//     -> StallM=0; next cycle ReadDataW=0x55.
//  5. TIMEOUT=4, load granted, no rvalid
//     -> bus_err 1-cycle pulse after 4 WAIT cycles; ReadDataW=0; late rvalid ignored.
//  6. Reset asserted in WAIT
//     -> next cycle dmem_req=0, StallM=0, W outputs 0; following rvalid dropped.
//     With MEM_MISALIGN_CHECK_EN, load at 0x82 -> no req, bus_err pulse, RegWriteW=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline slice: widths, LSU FSM states,
// MEM/WB register load select and the read data returned on a bus error.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // Value written to ReadDataW when a load is abandoned by timeout.
    localparam logic [DATA_W-1:0] BUS_ERR_RDATA = '0;

    typedef enum logic {
        IDLE,
        WAIT
    } lsu_state_e;

    // MEM/WB register update: take the M-stage values, or insert a bubble.
    typedef enum logic {
        WB_BUBBLE,
        WB_LOAD
    } wb_sel_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. On WB_LOAD all W fields take the M-side values;
// on WB_BUBBLE the write controls clear and the data fields hold.
module mem_wb_reg #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_W  = mips_pkg::REG_W
) (
    input  logic                clk,
    input  logic                reset,
    input  mips_pkg::wb_sel_e   sel,
    input  logic                RegWriteM,
    input  logic                MemtoRegM,
    input  logic [DATA_W-1:0]   ALUOutM,
    input  logic [REG_W-1:0]    WriteRegM,
    input  logic [DATA_W-1:0]   ReadDataM,
    output logic                RegWriteW,
    output logic                MemtoRegW,
    output logic [DATA_W-1:0]   ALUOutW,
    output logic [REG_W-1:0]    WriteRegW,
    output logic [DATA_W-1:0]   ReadDataW
);

    // W register: clear on reset, load on completion, bubble otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            ALUOutW   <= '0;
            WriteRegW <= '0;
            ReadDataW <= '0;
        end else if (sel == mips_pkg::WB_LOAD) begin
            RegWriteW <= RegWriteM;
            MemtoRegW <= MemtoRegM;
            ALUOutW   <= ALUOutM;
            WriteRegW <= WriteRegM;
            ReadDataW <= ReadDataM;
        end else begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_wb_lsu.sv
// MEM-stage load/store unit with MEM/WB boundary register.
// Issues one req/gnt/rvalid data-memory access per load/store, stalls the
// front of the pipe until it completes, and aborts a load with a bus_err
// pulse after TIMEOUT cycles without rvalid (TIMEOUT = 0 waits forever).
// Optional build macro MEM_MISALIGN_CHECK_EN: a memop whose address is not
// word aligned issues no request, retires as a bubble and pulses bus_err.
module mem_wb_lsu #(
    parameter int DATA_W  = mips_pkg::DATA_W,
    parameter int REG_W   = mips_pkg::REG_W,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                RegWriteM,
    input  logic                MemtoRegM,
    input  logic                MemWriteM,
    input  logic [DATA_W-1:0]   ALUOutM,
    input  logic [DATA_W-1:0]   WriteDataM,
    input  logic [REG_W-1:0]    WriteRegM,
    output logic                StallM,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [DATA_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic                dmem_gnt,
    input  logic                dmem_rvalid,
    input  logic [DATA_W-1:0]   dmem_rdata,
    output logic                RegWriteW,
    output logic                MemtoRegW,
    output logic [DATA_W-1:0]   ReadDataW,
    output logic [DATA_W-1:0]   ALUOutW,
    output logic [REG_W-1:0]    WriteRegW,
    output logic                bus_err
);

    import mips_pkg::*;

    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam int          CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_e         state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               memop;
    logic               misalign;
    logic               done;
    logic               err_d;
    logic [DATA_W-1:0]  rdata_d;
    wb_sel_e            wb_sel;

    assign memop      = MemtoRegM | MemWriteM;
    assign dmem_we    = MemWriteM;
    assign dmem_addr  = ALUOutM;
    assign dmem_wdata = WriteDataM;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = memop & (ALUOutM[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // FSM state, timeout counter and registered bus_err pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bus_err <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bus_err <= err_d;
        end
    end

    // Next state, request, completion and writeback read data
    always_comb begin
        state_d  = state;
        cnt_d    = '0;
        done     = 1'b0;
        err_d    = 1'b0;
        dmem_req = 1'b0;
        rdata_d  = '0;
        unique case (state)
            IDLE: begin
                if (memop) begin
                    if (misalign) begin
                        done  = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        dmem_req = ~reset;
                        if (dmem_gnt) begin
                            if (MemWriteM) begin
                                done = 1'b1;
                            end else if (dmem_rvalid) begin
                                done    = 1'b1;
                                rdata_d = dmem_rdata;
                            end else begin
                                state_d = WAIT;
                            end
                        end
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt + 1'b1;
                if (dmem_rvalid) begin
                    done    = 1'b1;
                    rdata_d = dmem_rdata;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (TIMEOUT != 0 && cnt == CNT_W'(TO_LAST)) begin
                    done    = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = DATA_W'(BUS_ERR_RDATA);
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stall the front of the pipe while a memop is still outstanding
    always_comb begin
        StallM = memop & ~done;
        wb_sel = (misalign || (memop && !done)) ? WB_BUBBLE : WB_LOAD;
    end

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb_reg (
        .clk       (clk),
        .reset     (reset),
        .sel       (wb_sel),
        .RegWriteM (RegWriteM),
        .MemtoRegM (MemtoRegM),
        .ALUOutM   (ALUOutM),
        .WriteRegM (WriteRegM),
        .ReadDataM (rdata_d),
        .RegWriteW (RegWriteW),
        .MemtoRegW (MemtoRegW),
        .ALUOutW   (ALUOutW),
        .WriteRegW (WriteRegW),
        .ReadDataW (ReadDataW)
    );

endmodule

// File: tb/tb_mem_wb_lsu.sv
// Bench for mem_wb_lsu: scenario tasks drive the M side and memory port,
// push the expected MEM/WB contents for each edge onto a scoreboard queue,
// and compare after the edge.
module tb_mem_wb_lsu;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          RegWriteM, MemtoRegM, MemWriteM;
    logic [DW-1:0] ALUOutM, WriteDataM;
    logic [RW-1:0] WriteRegM;
    logic          StallM, dmem_req, dmem_we;
    logic [DW-1:0] dmem_addr, dmem_wdata;
    logic          dmem_gnt, dmem_rvalid;
    logic [DW-1:0] dmem_rdata;
    logic          RegWriteW, MemtoRegW;
    logic [DW-1:0] ReadDataW, ALUOutW;
    logic [RW-1:0] WriteRegW;
    logic          bus_err;

    mem_wb_lsu #(
        .DATA_W  (DW),
        .REG_W   (RW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .RegWriteM   (RegWriteM),
        .MemtoRegM   (MemtoRegM),
        .MemWriteM   (MemWriteM),
        .ALUOutM     (ALUOutM),
        .WriteDataM  (WriteDataM),
        .WriteRegM   (WriteRegM),
        .StallM      (StallM),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .RegWriteW   (RegWriteW),
        .MemtoRegW   (MemtoRegW),
        .ReadDataW   (ReadDataW),
        .ALUOutW     (ALUOutW),
        .WriteRegW   (WriteRegW),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rw;
        logic          m2r;
        logic [DW-1:0] alu;
        logic [RW-1:0] wr;
        logic [DW-1:0] rd;
        logic          berr;
    } wb_t;

    wb_t exp_q[$];
    wb_t last_w;
    wb_t e;
    int  n_vec = 0;
    int  n_err = 0;

    function automatic wb_t obs_w();
        return {RegWriteW, MemtoRegW, ALUOutW, WriteRegW, ReadDataW, bus_err};
    endfunction

    function automatic wb_t pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    function automatic wb_t bubble_of(input wb_t l);
        return {1'b0, 1'b0, l.alu, l.wr, l.rd, 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_m(input logic rw, input logic m2r, input logic mw,
                           input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                           input logic [RW-1:0] wr);
        RegWriteM  = rw;
        MemtoRegM  = m2r;
        MemWriteM  = mw;
        ALUOutM    = alu;
        WriteDataM = wd;
        WriteRegM  = wr;
    endtask

    task automatic idle();
        drive_m(1'b0, 1'b0, 1'b0, '0, '0, '0);
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        step();
        last_w = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_m(1'b0, 1'b0, 1'b0, '0, '0, '0);
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        step();
        step();
        n_vec++;
        if (obs_w() !== wb_t'(0)) begin
            n_err++; $display("FAIL reset_w: got %h want %h", obs_w(), wb_t'(0));
        end
        n_vec++;
        if ({dmem_req, StallM} !== 2'b00) begin
            n_err++; $display("FAIL reset_req_stall: got %b want 00", {dmem_req, StallM});
        end
        reset  = 1'b0;
        last_w = '0;
    endtask

    task automatic test_alu_op();
        drive_m(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5);
        #1;
        n_vec++;
        if ({dmem_req, StallM} !== 2'b00) begin
            n_err++; $display("FAIL alu_req_stall: got %b want 00", {dmem_req, StallM});
        end
        exp_q.push_back({1'b1, 1'b0, 32'h1234, 5'd5, 32'h0, 1'b0});
        step();
        e = pop_exp();
        n_vec++;
        if (obs_w() !== e) begin
            n_err++; $display("FAIL alu_w: got %h want %h", obs_w(), e);
        end
        last_w = e;
        idle();
    endtask

    task automatic test_store();
        drive_m(1'b0, 1'b0, 1'b1, 32'h40, 32'hCAFE, 5'd7);
        for (int c = 0; c < 3; c++) begin
            dmem_gnt = (c == 2);
            #1;
            n_vec++;
            if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, StallM} !==
                {1'b1, 1'b1, 32'h40, 32'hCAFE, 1'(c < 2)}) begin
                n_err++;
                $display("FAIL store_port c%0d: got req=%b we=%b addr=%h wdata=%h stall=%b want 1 1 00000040 0000cafe %b",
                         c, dmem_req, dmem_we, dmem_addr, dmem_wdata, StallM, 1'(c < 2));
            end
            if (c < 2) exp_q.push_back(bubble_of(last_w));
            else       exp_q.push_back({1'b0, 1'b0, 32'h40, 5'd7, 32'h0, 1'b0});
            step();
            e = pop_exp();
            n_vec++;
            if (obs_w() !== e) begin
                n_err++; $display("FAIL store_w c%0d: got %h want %h", c, obs_w(), e);
            end
            last_w = e;
        end
        idle();
    endtask

    task automatic test_load_wait();
        drive_m(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 5'd9);
        for (int c = 0; c < 4; c++) begin
            // gnt stays high in WAIT, where no request is pending
            dmem_gnt    = 1'b1;
            dmem_rvalid = (c == 3);
            dmem_rdata  = (c == 3) ? 32'hBEEF : 32'hDEAD;
            #1;
            n_vec++;
            if ({dmem_req, dmem_we, StallM} !== {1'(c == 0), 1'b0, 1'(c < 3)}) begin
                n_err++;
                $display("FAIL load_port c%0d: got req/we/stall=%b want %b",
                         c, {dmem_req, dmem_we, StallM}, {1'(c == 0), 1'b0, 1'(c < 3)});
            end
            if (c < 3) exp_q.push_back(bubble_of(last_w));
            else       exp_q.push_back({1'b1, 1'b1, 32'h80, 5'd9, 32'hBEEF, 1'b0});
            step();
            e = pop_exp();
            n_vec++;
            if (obs_w() !== e) begin
                n_err++; $display("FAIL load_w c%0d: got %h want %h", c, obs_w(), e);
            end
            last_w = e;
        end
        idle();
    endtask

    task automatic test_zero_wait();
        drive_m(1'b1, 1'b1, 1'b0, 32'h84, 32'h0, 5'd3);
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h55;
        #1;
        n_vec++;
        if ({dmem_req, StallM} !== 2'b10) begin
            n_err++; $display("FAIL zw_req_stall: got %b want 10", {dmem_req, StallM});
        end
        exp_q.push_back({1'b1, 1'b1, 32'h84, 5'd3, 32'h55, 1'b0});
        step();
        e = pop_exp();
        n_vec++;
        if (obs_w() !== e) begin
            n_err++; $display("FAIL zw_w: got %h want %h", obs_w(), e);
        end
        last_w = e;
        idle();
    endtask

    task automatic test_timeout();
        drive_m(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd4);
        for (int c = 0; c <= TO; c++) begin
            dmem_gnt    = (c == 0);
            dmem_rvalid = 1'b0;
            dmem_rdata  = 32'hFFFF;
            #1;
            n_vec++;
            if ({dmem_req, StallM} !== {1'(c == 0), 1'(c < TO)}) begin
                n_err++;
                $display("FAIL to_req_stall c%0d: got %b want %b",
                         c, {dmem_req, StallM}, {1'(c == 0), 1'(c < TO)});
            end
            if (c < TO) exp_q.push_back(bubble_of(last_w));
            else        exp_q.push_back({1'b1, 1'b1, 32'h100, 5'd4, 32'h0, 1'b1});
            step();
            e = pop_exp();
            n_vec++;
            if (obs_w() !== e) begin
                n_err++; $display("FAIL to_w c%0d: got %h want %h", c, obs_w(), e);
            end
            last_w = e;
        end
        // late rvalid after the abort must not reach WB
        drive_m(1'b0, 1'b0, 1'b0, '0, '0, '0);
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h99;
        #1;
        n_vec++;
        if ({dmem_req, StallM} !== 2'b00) begin
            n_err++; $display("FAIL to_late_req_stall: got %b want 00", {dmem_req, StallM});
        end
        exp_q.push_back('0);
        step();
        e = pop_exp();
        n_vec++;
        if (obs_w() !== e) begin
            n_err++; $display("FAIL to_late_w: got %h want %h", obs_w(), e);
        end
        last_w = e;
        idle();
    endtask

    task automatic test_reset_mid();
        drive_m(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd6);
        dmem_gnt = 1'b1;
        #1;
        exp_q.push_back(bubble_of(last_w));
        step();
        e = pop_exp();
        n_vec++;
        if (obs_w() !== e) begin
            n_err++; $display("FAIL rm_wait_w: got %h want %h", obs_w(), e);
        end
        reset = 1'b1;
        drive_m(1'b0, 1'b0, 1'b0, '0, '0, '0);
        dmem_gnt = 1'b0;
        step();
        n_vec++;
        if (obs_w() !== wb_t'(0)) begin
            n_err++; $display("FAIL rm_reset_w: got %h want %h", obs_w(), wb_t'(0));
        end
        reset       = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h77;
        #1;
        n_vec++;
        if ({dmem_req, StallM} !== 2'b00) begin
            n_err++; $display("FAIL rm_req_stall: got %b want 00", {dmem_req, StallM});
        end
        exp_q.push_back('0);
        step();
        e = pop_exp();
        n_vec++;
        if (obs_w() !== e) begin
            n_err++; $display("FAIL rm_late_w: got %h want %h", obs_w(), e);
        end
        last_w = e;
        // FSM must be back in IDLE: a new load requests immediately
        dmem_rvalid = 1'b0;
        drive_m(1'b1, 1'b1, 1'b0, 32'h204, 32'h0, 5'd2);
        #1;
        n_vec++;
        if ({dmem_req, StallM} !== 2'b11) begin
            n_err++; $display("FAIL rm_new_req: got %b want 11", {dmem_req, StallM});
        end
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h33;
        exp_q.push_back({1'b1, 1'b1, 32'h204, 5'd2, 32'h33, 1'b0});
        step();
        e = pop_exp();
        n_vec++;
        if (obs_w() !== e) begin
            n_err++; $display("FAIL rm_new_w: got %h want %h", obs_w(), e);
        end
        last_w = e;
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            int unsigned   kind;
            logic [DW-1:0] a, d;
            logic [RW-1:0] wr;
            kind = $urandom_range(0, 2);
            a    = $urandom & 32'hFFFF_FFFC;
            d    = $urandom;
            wr   = RW'($urandom_range(0, 31));
            dmem_rdata  = d;
            dmem_gnt    = 1'($urandom_range(0, 1));
            dmem_rvalid = 1'($urandom_range(0, 1));
            if (kind == 0) begin
                drive_m(1'b1, 1'b0, 1'b0, a, d, wr);
                exp_q.push_back({1'b1, 1'b0, a, wr, 32'h0, 1'b0});
            end else if (kind == 1) begin
                drive_m(1'b1, 1'b1, 1'b0, a, 32'h0, wr);
                dmem_gnt    = 1'b1;
                dmem_rvalid = 1'b1;
                exp_q.push_back({1'b1, 1'b1, a, wr, d, 1'b0});
            end else begin
                drive_m(1'b0, 1'b0, 1'b1, a, d, wr);
                dmem_gnt = 1'b1;
                exp_q.push_back({1'b0, 1'b0, a, wr, 32'h0, 1'b0});
            end
            #1;
            n_vec++;
            if (StallM !== 1'b0) begin
                n_err++; $display("FAIL b2b_stall i%0d kind%0d: got %b want 0", i, kind, StallM);
            end
            step();
            e = pop_exp();
            n_vec++;
            if (obs_w() !== e) begin
                n_err++; $display("FAIL b2b_w i%0d kind%0d: got %h want %h", i, kind, obs_w(), e);
            end
            last_w = e;
        end
        idle();
    endtask

`ifdef MEM_MISALIGN_CHECK_EN
    task automatic test_misalign();
        drive_m(1'b1, 1'b0, 1'b0, 32'h4321, 32'h0, 5'd11);
        step();
        last_w = {1'b1, 1'b0, 32'h4321, 5'd11, 32'h0, 1'b0};
        drive_m(1'b1, 1'b1, 1'b0, 32'h82, 32'h0, 5'd8);
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111;
        #1;
        n_vec++;
        if ({dmem_req, StallM} !== 2'b00) begin
            n_err++; $display("FAIL mis_req_stall: got %b want 00", {dmem_req, StallM});
        end
        exp_q.push_back({1'b0, 1'b0, last_w.alu, last_w.wr, last_w.rd, 1'b1});
        step();
        e = pop_exp();
        n_vec++;
        if (obs_w() !== e) begin
            n_err++; $display("FAIL mis_w: got %h want %h", obs_w(), e);
        end
        last_w = e;
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_alu_op();
        test_store();
        test_load_wait();
        test_zero_wait();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
`ifdef MEM_MISALIGN_CHECK_EN
        test_misalign();
`endif
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1);
    end

endmodule
